// File: rtl/buf_seq.sv
`default_nettype none
// ============================================================================
// Module      : buf_seq
// Description : Sequencer for the CUBIC_D^3 transpose buffer. Accepts sample
//               pairs from the upstream FFT stage in col/dep/row order, then
//               streams the whole cube back out in row/col/dep order (a
//               sequential sweep of the buffer address space). Write and read
//               phases never overlap because the buffer shares one set of
//               index ports.
// Ports       : clock     - system clock, rising edge
//               reset     - asynchronous, active-low
//               start     - 1-cycle pulse, starts a frame when idle
//               in_valid  - upstream sample pair valid
//               in_ready  - high during the write phase
//               mem_wr    - buffer write strobe (in_valid & in_ready)
//               mem_rd    - buffer read strobe (registered)
//               row_no    - row pair index, 0..HALF_D-1
//               col_no    - column index, 0..CUBIC_D-1
//               dep_no    - depth index, 0..CUBIC_D-1
//               out_valid - buffer read data valid (mem_rd delayed RD_LAT)
//               out_last  - with out_valid: last read pair of the frame
//               busy      - a frame is in progress
//               done      - 1-cycle pulse when the frame completes
// Revision    : 1.0 - initial release
// ============================================================================
module buf_seq #(
    parameter int CUBIC_D = 96,
    parameter int HALF_D  = 48,
    parameter int RD_LAT  = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       mem_wr,
    output logic       mem_rd,
    output logic [6:0] row_no,
    output logic [6:0] col_no,
    output logic [6:0] dep_no,
    output logic       out_valid,
    output logic       out_last,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WRITE = 2'd1;
    localparam logic [1:0] c_READ  = 2'd2;
    localparam logic [1:0] c_DRAIN = 2'd3;

    localparam logic [6:0] c_ROW_MAX = 7'(HALF_D - 1);
    localparam logic [6:0] c_CD_MAX  = 7'(CUBIC_D - 1);

    localparam int               c_DW        = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [c_DW-1:0]  c_DRAIN_MAX = c_DW'(RD_LAT - 1);

    logic [1:0]        r_state;
    logic [6:0]        r_row;
    logic [6:0]        r_col;
    logic [6:0]        r_dep;
    logic              r_mem_rd;
    logic              r_done;
    logic [c_DW-1:0]   r_drain;
    logic [RD_LAT-1:0] r_vld_pipe;
    logic [RD_LAT-1:0] r_last_pipe;

    logic w_accept;
    logic w_row_end;
    logic w_col_end;
    logic w_dep_end;
    logic w_cube_end;
    logic w_start_ok;

    assign w_accept   = in_valid & (r_state == c_WRITE);
    assign w_row_end  = (r_row == c_ROW_MAX);
    assign w_col_end  = (r_col == c_CD_MAX);
    assign w_dep_end  = (r_dep == c_CD_MAX);
    assign w_cube_end = w_row_end & w_col_end & w_dep_end;
    // State is already IDLE in the done cycle; a start coinciding with done
    // must not launch a frame, so done gates it as well.
    assign w_start_ok = start & (r_state == c_IDLE) & ~r_done;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= c_IDLE;
            r_row    <= 7'd0;
            r_col    <= 7'd0;
            r_dep    <= 7'd0;
            r_mem_rd <= 1'b0;
            r_done   <= 1'b0;
            r_drain  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_start_ok) begin
                        r_state <= c_WRITE;
                    end
                end
                c_WRITE: begin
                    // Write order: col fastest, then dep, then row.
                    if (w_accept) begin
                        if (w_cube_end) begin
                            r_row    <= 7'd0;
                            r_col    <= 7'd0;
                            r_dep    <= 7'd0;
                            r_mem_rd <= 1'b1;
                            r_state  <= c_READ;
                        end else if (w_col_end) begin
                            r_col <= 7'd0;
                            if (w_dep_end) begin
                                r_dep <= 7'd0;
                                r_row <= r_row + 7'd1;
                            end else begin
                                r_dep <= r_dep + 7'd1;
                            end
                        end else begin
                            r_col <= r_col + 7'd1;
                        end
                    end
                end
                c_READ: begin
                    // Read order: row fastest, then col, then dep. This walks
                    // the buffer address dep*D*D + col*D + 2*row sequentially.
                    if (w_cube_end) begin
                        r_row    <= 7'd0;
                        r_col    <= 7'd0;
                        r_dep    <= 7'd0;
                        r_mem_rd <= 1'b0;
                        r_drain  <= '0;
                        r_state  <= c_DRAIN;
                    end else if (w_row_end) begin
                        r_row <= 7'd0;
                        if (w_col_end) begin
                            r_col <= 7'd0;
                            r_dep <= r_dep + 7'd1;
                        end else begin
                            r_col <= r_col + 7'd1;
                        end
                    end else begin
                        r_row <= r_row + 7'd1;
                    end
                end
                c_DRAIN: begin
                    // Wait out the buffer read latency so the final
                    // out_valid lands in the last DRAIN cycle.
                    if (r_drain == c_DRAIN_MAX) begin
                        r_state <= c_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Read-latency alignment pipe for out_valid / out_last.
    generate
        if (RD_LAT == 1) begin : g_pipe_single
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_vld_pipe  <= '0;
                    r_last_pipe <= '0;
                end else begin
                    r_vld_pipe  <= r_mem_rd;
                    r_last_pipe <= r_mem_rd & w_cube_end;
                end
            end
        end else begin : g_pipe_multi
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_vld_pipe  <= '0;
                    r_last_pipe <= '0;
                end else begin
                    r_vld_pipe  <= {r_vld_pipe[RD_LAT-2:0], r_mem_rd};
                    r_last_pipe <= {r_last_pipe[RD_LAT-2:0], r_mem_rd & w_cube_end};
                end
            end
        end
    endgenerate

    assign in_ready  = (r_state == c_WRITE);
    assign mem_wr    = w_accept;
    assign mem_rd    = r_mem_rd;
    assign row_no    = r_row;
    assign col_no    = r_col;
    assign dep_no    = r_dep;
    assign out_valid = r_vld_pipe[RD_LAT-1];
    assign out_last  = r_last_pipe[RD_LAT-1];
    assign busy      = (r_state != c_IDLE);
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_buf_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_buf_seq
// Description : Self-checking bench for buf_seq on a reduced 8x8x(2*4) cube.
//               A behavioural buffer with 2-cycle read latency stores the
//               flat write index, so read data reveals both the scan order
//               and the out_valid alignment.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_buf_seq;

    localparam int D     = 8;
    localparam int H     = 4;
    localparam int LAT   = 2;
    localparam int NB    = D * D * H;
    localparam int LIMIT = 4 * NB + 100;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       mem_wr;
    logic       mem_rd;
    logic [6:0] row_no;
    logic [6:0] col_no;
    logic [6:0] dep_no;
    logic       out_valid;
    logic       out_last;
    logic       busy;
    logic       done;

    buf_seq #(.CUBIC_D(D), .HALF_D(H), .RD_LAT(LAT)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mem_wr   (mem_wr),
        .mem_rd   (mem_rd),
        .row_no   (row_no),
        .col_no   (col_no),
        .dep_no   (dep_no),
        .out_valid(out_valid),
        .out_last (out_last),
        .busy     (busy),
        .done     (done)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural transpose buffer ----------------
    int mem [0:2*NB-1];
    int wr_flat = 0;
    int rd_d1 = -1;
    int rd_d2 = -1;
    int addr;

    always_comb addr = int'(dep_no) * D * D + int'(col_no) * D + 2 * int'(row_no);

    always @(posedge clock) begin
        if (mem_wr && addr < 2 * NB) begin
            mem[addr] <= wr_flat;
            wr_flat   <= (wr_flat == NB - 1) ? 0 : wr_flat + 1;
        end
        rd_d1 <= (mem_rd && addr < 2 * NB) ? mem[addr] : -1;
        rd_d2 <= rd_d1;
    end

    // ---------------- checkpoint tables ----------------
    typedef struct {
        string name;
        int    idx;
        int    r;
        int    c;
        int    d;
    } vec_t;

    vec_t wvec[5];
    vec_t rvec[5];

    int wr_r[NB], wr_c[NB], wr_d[NB];
    int rd_r[NB], rd_c[NB], rd_d[NB];

    task automatic run_frame(input string tag, input int stall_pct, input bit poke);
        int nw = 0, nr = 0, nv = 0, cyc = 0, nlast = 0, last_at = -10;
        int bad_wr = 0, bad_rd = 0, bad_data = 0, exp;
        bit fin = 0, after_wr = 0;
        @(posedge clock); #1;
        start = 1'b1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        start = 1'b0;
        while (!fin && cyc < LIMIT) begin
            in_valid = ($urandom_range(99) >= stall_pct);
            start = poke && (cyc == 10 || nr == 20);
            @(negedge clock);
            if (after_wr) begin
                check({tag, " mem_rd_after_last_beat"}, int'(mem_rd), 1);
                check({tag, " in_ready_after_last_beat"}, int'(in_ready), 0);
                after_wr = 0;
            end
            if (mem_wr) begin
                if (nw < NB) begin
                    wr_r[nw] = row_no; wr_c[nw] = col_no; wr_d[nw] = dep_no;
                end
                nw++;
                if (nw == NB) after_wr = 1;
            end
            if (mem_rd) begin
                if (nr < NB) begin
                    rd_r[nr] = row_no; rd_c[nr] = col_no; rd_d[nr] = dep_no;
                end
                nr++;
            end
            if (out_valid) begin
                exp = (nv % H) * D * D + (nv / (H * D)) * D + ((nv / H) % D);
                if (rd_d2 != exp) begin
                    if (bad_data == 0)
                        $display("FAIL %s read_data[%0d]: got %0d expected %0d", tag, nv, rd_d2, exp);
                    bad_data++;
                end
                if (out_last) begin
                    nlast++;
                    last_at = cyc;
                    check({tag, " out_last_position"}, nv, NB - 1);
                end
                nv++;
            end
            if (done) begin
                fin = 1;
                check({tag, " done_one_after_last"}, cyc - 1, last_at);
                check({tag, " busy_at_done"}, int'(busy), 0);
            end
            if (!fin) begin
                @(posedge clock); #1;
                cyc++;
            end
        end
        check({tag, " frame_completed_in_budget"}, int'(fin), 1);
        check({tag, " mem_wr_count"}, nw, NB);
        check({tag, " mem_rd_count"}, nr, NB);
        check({tag, " out_valid_count"}, nv, NB);
        check({tag, " out_last_count"}, nlast, 1);
        check({tag, " read_data_errors"}, bad_data, 0);
        for (int i = 0; i < 5; i++) begin
            check({tag, " wr ", wvec[i].name, " row"}, wr_r[wvec[i].idx], wvec[i].r);
            check({tag, " wr ", wvec[i].name, " col"}, wr_c[wvec[i].idx], wvec[i].c);
            check({tag, " wr ", wvec[i].name, " dep"}, wr_d[wvec[i].idx], wvec[i].d);
            check({tag, " rd ", rvec[i].name, " row"}, rd_r[rvec[i].idx], rvec[i].r);
            check({tag, " rd ", rvec[i].name, " col"}, rd_c[rvec[i].idx], rvec[i].c);
            check({tag, " rd ", rvec[i].name, " dep"}, rd_d[rvec[i].idx], rvec[i].d);
        end
        for (int k = 0; k < NB; k++) begin
            if (wr_r[k] != k / (D * D) || wr_c[k] != k % D || wr_d[k] != (k / D) % D)
                bad_wr++;
            if (rd_r[k] != k % H || rd_c[k] != (k / H) % D || rd_d[k] != k / (H * D))
                bad_rd++;
        end
        check({tag, " write_scan_mismatches"}, bad_wr, 0);
        check({tag, " read_scan_mismatches"}, bad_rd, 0);
    endtask

    task automatic reset_mid_read();
        int n = 0, cyc = 0;
        @(posedge clock); #1;
        start = 1'b1;
        in_valid = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        while (n < 100 && cyc < LIMIT) begin
            @(negedge clock);
            if (mem_rd) n++;
            cyc++;
        end
        check("abort reached_100_reads", n, 100);
        #2 reset = 1'b0;
        #1;
        check("abort busy", int'(busy), 0);
        check("abort mem_rd", int'(mem_rd), 0);
        check("abort in_ready", int'(in_ready), 0);
        check("abort mem_wr", int'(mem_wr), 0);
        check("abort out_valid", int'(out_valid), 0);
        check("abort out_last", int'(out_last), 0);
        check("abort done", int'(done), 0);
        check("abort indices", int'({row_no, col_no, dep_no}), 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("post_abort no_done", int'(done), 0);
            check("post_abort idle_no_mem_wr", int'(mem_wr), 0);
        end
    endtask

    initial begin
        wvec[0] = '{"beat0",      0,          0,     0,     0};
        wvec[1] = '{"beatD-1",    D - 1,      0,     D - 1, 0};
        wvec[2] = '{"beatD",      D,          0,     0,     1};
        wvec[3] = '{"beatDD",     D * D,      1,     0,     0};
        wvec[4] = '{"beat_last",  NB - 1,     H - 1, D - 1, D - 1};
        rvec[0] = '{"read0",      0,          0,     0,     0};
        rvec[1] = '{"readH-1",    H - 1,      H - 1, 0,     0};
        rvec[2] = '{"readH",      H,          0,     1,     0};
        rvec[3] = '{"readHD",     H * D,      0,     0,     1};
        rvec[4] = '{"read_last",  NB - 1,     H - 1, D - 1, D - 1};

        // Reset state, with in_valid asserted to show it has no effect.
        in_valid = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset busy", int'(busy), 0);
        check("reset in_ready", int'(in_ready), 0);
        check("reset mem_wr", int'(mem_wr), 0);
        check("reset mem_rd", int'(mem_rd), 0);
        check("reset out_valid", int'(out_valid), 0);
        check("reset out_last", int'(out_last), 0);
        check("reset done", int'(done), 0);
        check("reset indices", int'({row_no, col_no, dep_no}), 0);
        reset = 1'b1;
        @(negedge clock);
        check("idle in_valid no mem_wr", int'(mem_wr), 0);
        check("idle no start stays idle", int'(busy), 0);

        // Continuous input, with stray start pulses during WRITE and READ.
        run_frame("A", 0, 1'b1);

        // Start coinciding with done must be ignored.
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(negedge clock);
        check("start_on_done ignored", int'(busy), 0);

        // 50% stalls, then an immediate back-to-back frame.
        run_frame("B", 50, 1'b0);
        run_frame("C", 0, 1'b0);

        // Abort mid-READ, then a fresh frame.
        reset_mid_read();
        run_frame("D", 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
